// File: rtl/ex_mem_stage_pkg.sv
// Shared constants and types for the EX/MEM pipeline register stage.
package ex_mem_stage_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned REG_AW_DEF = 4;

    localparam int unsigned FLAG_W = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 0;

    localparam int unsigned            RETIRE_W   = 16;
    localparam logic [RETIRE_W-1:0]    RETIRE_MAX = '1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } stage_state_t;

    typedef struct packed {
        logic reg_we;
        logic mem_rd;
        logic mem_wr;
        logic halt;
    } ctrl_t;

    // Bits selected by mask take new data, the rest keep their old value.
    function automatic logic [FLAG_W-1:0] masked_update(
        input logic [FLAG_W-1:0] old_q,
        input logic [FLAG_W-1:0] new_d,
        input logic [FLAG_W-1:0] mask
    );
        return (old_q & ~mask) | (new_d & mask);
    endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX-side instruction bus into the stage and the registered MEM-side bus out of it.
interface ex_mem_stage_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4
);
    logic              ex_valid;
    logic [DATA_W-1:0] ex_result;
    logic [DATA_W-1:0] ex_store_data;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_we;
    logic              ex_mem_rd;
    logic              ex_mem_wr;
    logic              ex_halt;
    logic [2:0]        ex_flags;
    logic [2:0]        ex_flag_mask;

    logic              mem_valid;
    logic              mem_reg_we;
    logic              mem_mem_rd;
    logic              mem_mem_wr;
    logic              mem_halt;
    logic [DATA_W-1:0] mem_result;
    logic [DATA_W-1:0] mem_store_data;
    logic [REG_AW-1:0] mem_rd;

    // Execute side: drives instructions, observes the MEM register.
    modport master (
        output ex_valid, ex_result, ex_store_data, ex_rd,
               ex_reg_we, ex_mem_rd, ex_mem_wr, ex_halt, ex_flags, ex_flag_mask,
        input  mem_valid, mem_reg_we, mem_mem_rd, mem_mem_wr, mem_halt,
               mem_result, mem_store_data, mem_rd
    );

    modport slave (
        input  ex_valid, ex_result, ex_store_data, ex_rd,
               ex_reg_we, ex_mem_rd, ex_mem_wr, ex_halt, ex_flags, ex_flag_mask,
        output mem_valid, mem_reg_we, mem_mem_rd, mem_mem_wr, mem_halt,
               mem_result, mem_store_data, mem_rd
    );

endinterface

// File: rtl/flag_reg.sv
// Architectural {Z,V,N} flag register with per-bit write mask.
module flag_reg
    import ex_mem_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [FLAG_W-1:0] i_mask,
    input  logic [FLAG_W-1:0] i_d,
    output logic [FLAG_W-1:0] o_q
);

    logic [FLAG_W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_we) begin
            r_q <= masked_update(r_q, i_d, i_mask);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with flush/stall, sticky halt, masked flags and retire counter.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                flush,
    ex_mem_stage_if.slave       bus,
    output logic [FLAG_W-1:0]   flags,
    output logic                halted,
    output logic [RETIRE_W-1:0] retire_cnt
);

    stage_state_t        r_state;
    stage_state_t        w_state_nxt;
    logic                w_cap;
    ctrl_t               w_ex_ctrl;

    logic                r_valid;
    ctrl_t               r_ctrl;
    logic [DATA_W-1:0]   r_result;
    logic [DATA_W-1:0]   r_store_data;
    logic [REG_AW-1:0]   r_rd;
    logic [RETIRE_W-1:0] r_retire_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Halt is sticky: only reset leaves ST_HALT.
    always_comb begin
        w_state_nxt = r_state;
        if ((r_state == ST_RUN) && w_cap && bus.ex_halt) begin
            w_state_nxt = ST_HALT;
        end
    end

    always_comb begin
        w_cap = 1'b0;
        if ((r_state == ST_RUN) && bus.ex_valid && !flush && !stall) begin
            w_cap = 1'b1;
        end
    end

    always_comb begin
        w_ex_ctrl        = '0;
        w_ex_ctrl.reg_we = bus.ex_reg_we;
        w_ex_ctrl.mem_rd = bus.ex_mem_rd;
        w_ex_ctrl.mem_wr = bus.ex_mem_wr;
        w_ex_ctrl.halt   = bus.ex_halt;
    end

    // Flush beats stall; an idle non-stalled cycle inserts a bubble but keeps data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_ctrl       <= '0;
            r_result     <= '0;
            r_store_data <= '0;
            r_rd         <= '0;
        end else if (flush) begin
            r_valid      <= 1'b0;
            r_ctrl       <= '0;
            r_result     <= '0;
            r_store_data <= '0;
            r_rd         <= '0;
        end else if (!stall) begin
            r_valid <= w_cap;
            r_ctrl  <= w_cap ? w_ex_ctrl : '0;
            if (w_cap) begin
                r_result     <= bus.ex_result;
                r_store_data <= bus.ex_store_data;
                r_rd         <= bus.ex_rd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= '0;
        end else if (w_cap && (r_retire_cnt != RETIRE_MAX)) begin
            r_retire_cnt <= r_retire_cnt + RETIRE_W'(1);
        end
    end

    flag_reg u_flag_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (w_cap),
        .i_mask (bus.ex_flag_mask),
        .i_d    (bus.ex_flags),
        .o_q    (flags)
    );

    assign bus.mem_valid      = r_valid;
    assign bus.mem_reg_we     = r_ctrl.reg_we;
    assign bus.mem_mem_rd     = r_ctrl.mem_rd;
    assign bus.mem_mem_wr     = r_ctrl.mem_wr;
    assign bus.mem_halt       = r_ctrl.halt;
    assign bus.mem_result     = r_result;
    assign bus.mem_store_data = r_store_data;
    assign bus.mem_rd         = r_rd;

    assign halted     = (r_state == ST_HALT);
    assign retire_cnt = r_retire_cnt;

endmodule
